// File: rtl/astropix_spi_responder_emu.sv
// AstroPix-side QSPI responder emulation: oversamples the SPI pins in the core
// clock domain, serializes frame bytes onto MISO and deserializes MOSI bytes.
module astropix_spi_responder_emu #(
    parameter logic [7:0]  IDLE_BYTE   = 8'hBC,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resn,
    input  logic       spi_clk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic [1:0] spi_miso,
    output logic       interruptn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       stat_mosi_overflow,
    output logic       stat_frame_sent
);

    localparam int unsigned NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Pin synchronizers plus one extra copy for edge detection
    logic [NS-1:0] sclk_sync_q;
    logic [NS-1:0] csn_sync_q;
    logic [NS-1:0] mosi_sync_q;
    logic          sclk_prev_q;
    logic          csn_prev_q;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[NS-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[NS-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[NS-2:0], spi_mosi};
            sclk_prev_q <= sclk_sync_q[NS-1];
            csn_prev_q  <= csn_sync_q[NS-1];
        end
    end

    logic sclk_s;
    logic csn_s;
    logic mosi_s;
    logic rise_c;
    logic fall_c;
    logic cs_start_c;
    logic cs_end_c;

    assign sclk_s     = sclk_sync_q[NS-1];
    assign csn_s      = csn_sync_q[NS-1];
    assign mosi_s     = mosi_sync_q[NS-1];
    assign rise_c     = sclk_s && !sclk_prev_q;
    assign fall_c     = !sclk_s && sclk_prev_q;
    assign cs_start_c = !csn_s && csn_prev_q;
    assign cs_end_c   = csn_s && !csn_prev_q;

    state_e state_q;

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (cs_start_c) state_q <= ST_SHIFT;
                ST_SHIFT: if (cs_end_c)   state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    logic [7:0] shreg_q,    shreg_d;
    logic [1:0] clk_cnt_q,  clk_cnt_d;
    logic [7:0] rx_q,       rx_d;
    logic [2:0] rx_cnt_q,   rx_cnt_d;
    logic       in_frame_q, in_frame_d;
    logic [1:0] miso_q,     miso_d;
    logic       tready_q,   tready_d;
    logic       sent_q,     sent_d;
    logic [7:0] m_data_q,   m_data_d;
    logic       m_valid_q,  m_valid_d;
    logic       ovf_q,      ovf_d;
    logic       intn_q,     intn_d;

    // cs_end takes priority over any clock edge seen in the same cycle
    logic       shifting_c;
    logic       next_shift_c;
    logic       load_c;
    logic [7:0] rx_byte_c;

    assign shifting_c   = (state_q == ST_SHIFT) && !cs_end_c;
    assign next_shift_c = (state_q == ST_IDLE) ? cs_start_c : !cs_end_c;
    assign load_c       = ((state_q == ST_IDLE) && cs_start_c)
                        || (shifting_c && fall_c && (clk_cnt_q == 2'd3));
    assign rx_byte_c    = {mosi_s, rx_q[7:1]};

    always_comb begin
        shreg_d    = shreg_q;
        clk_cnt_d  = clk_cnt_q;
        rx_d       = rx_q;
        rx_cnt_d   = rx_cnt_q;
        in_frame_d = in_frame_q;
        miso_d     = 2'b00;
        tready_d   = 1'b0;
        sent_d     = 1'b0;
        m_data_d   = m_data_q;
        m_valid_d  = m_valid_q;
        ovf_d      = 1'b0;
        intn_d     = !(s_axis_tvalid || in_frame_q);

        // MISO: a load replaces the shift on the fall that ends a byte
        if (load_c) begin
            clk_cnt_d = 2'd0;
            if (s_axis_tvalid) begin
                shreg_d    = s_axis_tdata;
                tready_d   = 1'b1;
                in_frame_d = !s_axis_tlast;
                sent_d     = s_axis_tlast;
            end else begin
                shreg_d = IDLE_BYTE;
            end
        end else if (shifting_c && fall_c) begin
            shreg_d   = {2'b00, shreg_q[7:2]};
            clk_cnt_d = clk_cnt_q + 2'd1;
        end

        // MOSI: a completed byte is dropped only if the held one is still stalled
        if (m_valid_q && m_axis_tready) begin
            m_valid_d = 1'b0;
        end
        if (shifting_c && rise_c) begin
            rx_d     = rx_byte_c;
            rx_cnt_d = rx_cnt_q + 3'd1;
            if (rx_cnt_q == 3'd7) begin
                if (!m_valid_q || m_axis_tready) begin
                    m_data_d  = rx_byte_c;
                    m_valid_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        // Outside a CS the counters sit at zero, dropping any partial MOSI byte
        if (!next_shift_c) begin
            clk_cnt_d = 2'd0;
            rx_cnt_d  = 3'd0;
        end else begin
            miso_d = shreg_d[1:0];
        end
    end

    always_ff @(posedge clk or negedge resn) begin
        if (!resn) begin
            shreg_q    <= '0;
            clk_cnt_q  <= '0;
            rx_q       <= '0;
            rx_cnt_q   <= '0;
            in_frame_q <= 1'b0;
            miso_q     <= 2'b00;
            tready_q   <= 1'b0;
            sent_q     <= 1'b0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            ovf_q      <= 1'b0;
            intn_q     <= 1'b1;
        end else begin
            shreg_q    <= shreg_d;
            clk_cnt_q  <= clk_cnt_d;
            rx_q       <= rx_d;
            rx_cnt_q   <= rx_cnt_d;
            in_frame_q <= in_frame_d;
            miso_q     <= miso_d;
            tready_q   <= tready_d;
            sent_q     <= sent_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            ovf_q      <= ovf_d;
            intn_q     <= intn_d;
        end
    end

    assign spi_miso           = miso_q;
    assign interruptn         = intn_q;
    assign s_axis_tready      = tready_q;
    assign m_axis_tdata       = m_data_q;
    assign m_axis_tvalid      = m_valid_q;
    assign stat_mosi_overflow = ovf_q;
    assign stat_frame_sent    = sent_q;

endmodule

// File: tb/tb_astropix_spi_responder_emu.sv
// Bench for astropix_spi_responder_emu: a bit-banged SPI master, an AXI-Stream
// source/sink, and a queue-level model of loads, frames and MOSI bytes.
module tb_astropix_spi_responder_emu;

    localparam logic [7:0] IDLE = 8'hBC;
    localparam int H = 6;

    logic       clk = 1'b0;
    logic       resn = 1'b0;
    logic       spi_clk = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [1:0] spi_miso;
    logic       interruptn;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       stat_mosi_overflow;
    logic       stat_frame_sent;

    astropix_spi_responder_emu dut (
        .clk                (clk),
        .resn               (resn),
        .spi_clk            (spi_clk),
        .spi_csn            (spi_csn),
        .spi_mosi           (spi_mosi),
        .spi_miso           (spi_miso),
        .interruptn         (interruptn),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tready      (m_axis_tready),
        .stat_mosi_overflow (stat_mosi_overflow),
        .stat_frame_sent    (stat_frame_sent)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } axb_t;

    typedef struct {
        bit         push;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_b0;
        logic [7:0] exp_rx;
    } vec_t;

    axb_t       tx_q[$];
    axb_t       mdl_q[$];
    bit         mdl_in_frame = 1'b0;
    int         exp_sent = 0;
    logic [1:0] exp_pairs[$];
    logic [7:0] exp_rx[$];
    logic [1:0] miso_got[$];
    logic [7:0] rx_got[$];
    int         sent_cnt = 0;
    int         ovf_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         hs_pend = 1'b0;

    // AXI-Stream source: inputs change 1 ns after the edge; pop after handshake
    always @(posedge clk) begin
        #1;
        if (!resn) begin
            hs_pend       = 1'b0;
            s_axis_tvalid = 1'b0;
        end else begin
            if (hs_pend && tx_q.size() > 0) tx_q.delete(0);
            s_axis_tvalid = (tx_q.size() > 0);
            if (tx_q.size() > 0) begin
                s_axis_tdata = tx_q[0].data;
                s_axis_tlast = tx_q[0].last;
            end
            hs_pend = s_axis_tvalid && s_axis_tready;
        end
    end

    always @(negedge clk) begin
        if (resn) begin
            if (m_axis_tvalid && m_axis_tready) rx_got.push_back(m_axis_tdata);
            if (stat_frame_sent) sent_cnt++;
            if (stat_mosi_overflow) ovf_cnt++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit last);
        tx_q.push_back(axb_t'{last: last, data: d});
        mdl_q.push_back(axb_t'{last: last, data: d});
    endtask

    // One load at CS start and one per 4 completed clocks, unless csn rose on the last fall
    task automatic model_cs(input int nclk, input logic [63:0] bits, input bit simul);
        logic [7:0] bytes[$];
        logic [7:0] b;
        axb_t       e;
        int         loads;
        loads = 1 + (simul ? (nclk - 1) / 4 : nclk / 4);
        exp_pairs.delete();
        exp_rx.delete();
        for (int l = 0; l < loads; l++) begin
            if (mdl_q.size() > 0) begin
                e = mdl_q.pop_front();
                b = e.data;
                mdl_in_frame = !e.last;
                if (e.last) exp_sent++;
            end else begin
                b = IDLE;
            end
            bytes.push_back(b);
        end
        for (int k = 0; k < nclk; k++) begin
            b = bytes[k / 4] >> (2 * (k % 4));
            exp_pairs.push_back(b[1:0]);
        end
        for (int j = 0; j < nclk / 8; j++) exp_rx.push_back(bits[8*j +: 8]);
    endtask

    task automatic spi_cs(input int nclk, input logic [63:0] bits, input bit simul);
        miso_got.delete();
        tick(1);
        spi_csn  = 1'b0;
        spi_mosi = 1'b0;
        tick(H + 2);
        for (int k = 0; k < nclk; k++) begin
            spi_mosi = bits[k];
            tick(H);
            miso_got.push_back(spi_miso);
            spi_clk = 1'b1;
            tick(H);
            spi_clk = 1'b0;
            if (simul && k == nclk - 1) spi_csn = 1'b1;
        end
        if (!simul) begin
            tick(H);
            spi_csn = 1'b1;
        end
        tick(H + 4);
    endtask

    task automatic do_cs(input int nclk, input logic [63:0] bits, input bit simul, input bit chk_rx);
        model_cs(nclk, bits, simul);
        rx_got.delete();
        spi_cs(nclk, bits, simul);
        chk("miso_count", 64'(miso_got.size()), 64'(exp_pairs.size()));
        for (int k = 0; k < exp_pairs.size() && k < miso_got.size(); k++)
            chk($sformatf("miso_pair%0d", k), 64'(miso_got[k]), 64'(exp_pairs[k]));
        if (chk_rx) begin
            chk("rx_count", 64'(rx_got.size()), 64'(exp_rx.size()));
            for (int j = 0; j < exp_rx.size() && j < rx_got.size(); j++)
                chk($sformatf("rx_byte%0d", j), 64'(rx_got[j]), 64'(exp_rx[j]));
        end
        chk("frame_sent_cnt", 64'(sent_cnt), 64'(exp_sent));
        chk("interruptn_after_cs", 64'(interruptn), 64'(!(mdl_q.size() > 0 || mdl_in_frame)));
        chk("miso_idle", 64'(spi_miso), 64'd0);
    endtask

    function automatic logic [7:0] got_byte(input int i);
        logic [7:0] b;
        b = 8'h00;
        for (int j = 0; j < 4; j++)
            if (4 * i + j < miso_got.size()) b[2*j +: 2] = miso_got[4*i + j];
        return b;
    endfunction

    initial begin
        vec_t vecs[5];
        int   ovf0;
        vecs[0] = '{push: 1'b1, tx: 8'h5A, mosi: 8'h0F, exp_b0: 8'h5A, exp_rx: 8'h0F};
        vecs[1] = '{push: 1'b0, tx: 8'h00, mosi: 8'hFF, exp_b0: 8'hBC, exp_rx: 8'hFF};
        vecs[2] = '{push: 1'b1, tx: 8'hC3, mosi: 8'h81, exp_b0: 8'hC3, exp_rx: 8'h81};
        vecs[3] = '{push: 1'b1, tx: 8'h00, mosi: 8'h00, exp_b0: 8'h00, exp_rx: 8'h00};
        vecs[4] = '{push: 1'b0, tx: 8'h00, mosi: 8'h96, exp_b0: 8'hBC, exp_rx: 8'h96};

        // Reset values, during and after reset with idle pins
        tick(4);
        chk("rst_miso", 64'(spi_miso), 64'd0);
        chk("rst_intn", 64'(interruptn), 64'd1);
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        resn = 1'b1;
        tick(6);
        chk("idle_miso", 64'(spi_miso), 64'd0);
        chk("idle_intn", 64'(interruptn), 64'd1);
        chk("idle_tready", 64'(s_axis_tready), 64'd0);
        chk("idle_mvalid", 64'(m_axis_tvalid), 64'd0);
        chk("idle_mdata", 64'(m_axis_tdata), 64'd0);
        chk("idle_ovf", 64'(stat_mosi_overflow), 64'd0);
        chk("idle_sent", 64'(stat_frame_sent), 64'd0);

        // Idle byte, LSB pair first
        do_cs(4, 64'h0, 1'b0, 1'b1);
        chk("bc_pair0", 64'(miso_got[0]), 64'd0);
        chk("bc_pair1", 64'(miso_got[1]), 64'd3);
        chk("bc_pair2", 64'(miso_got[2]), 64'd3);
        chk("bc_pair3", 64'(miso_got[3]), 64'd2);

        // Three-byte frame over a 16-clock CS
        push_frame(8'h01, 1'b0);
        push_frame(8'h02, 1'b0);
        push_frame(8'h03, 1'b1);
        tick(2);
        chk("intn_low_on_push", 64'(interruptn), 64'd0);
        do_cs(16, 64'h3CA5, 1'b0, 1'b1);
        chk("frame_b0", 64'(got_byte(0)), 64'h01);
        chk("frame_b1", 64'(got_byte(1)), 64'h02);
        chk("frame_b2", 64'(got_byte(2)), 64'h03);
        chk("frame_b3", 64'(got_byte(3)), 64'hBC);
        chk("frame_sent_once", 64'(sent_cnt), 64'd1);
        chk("mosi_a5", 64'(rx_got.size() > 0 ? rx_got[0] : 8'h00), 64'hA5);
        chk("mosi_3c", 64'(rx_got.size() > 1 ? rx_got[1] : 8'h00), 64'h3C);

        // Table of single-byte exchanges
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].push) push_frame(vecs[i].tx, 1'b1);
            do_cs(8, 64'(vecs[i].mosi), 1'b0, 1'b1);
            chk($sformatf("tbl%0d_b0", i), 64'(got_byte(0)), 64'(vecs[i].exp_b0));
            chk($sformatf("tbl%0d_b1", i), 64'(got_byte(1)), 64'(IDLE));
            chk($sformatf("tbl%0d_rx", i), 64'(rx_got.size() > 0 ? rx_got[0] : 8'hXX), 64'(vecs[i].exp_rx));
        end

        // Stalled sink: second byte dropped, first held
        @(posedge clk); #1 m_axis_tready = 1'b0;
        ovf0 = ovf_cnt;
        do_cs(16, 64'h3CA5, 1'b0, 1'b0);
        chk("ovf_mvalid", 64'(m_axis_tvalid), 64'd1);
        chk("ovf_mdata", 64'(m_axis_tdata), 64'hA5);
        chk("ovf_pulses", 64'(ovf_cnt - ovf0), 64'd1);
        rx_got.delete();
        @(posedge clk); #1 m_axis_tready = 1'b1;
        tick(3);
        chk("ovf_drain_cnt", 64'(rx_got.size()), 64'd1);
        chk("ovf_drain_byte", 64'(rx_got.size() > 0 ? rx_got[0] : 8'h00), 64'hA5);
        chk("ovf_drain_valid", 64'(m_axis_tvalid), 64'd0);

        // csn rises mid-byte: partial MOSI dropped, frame resumes next CS
        push_frame(8'h11, 1'b0);
        push_frame(8'h22, 1'b1);
        do_cs(2, 64'h3, 1'b0, 1'b1);
        chk("mid_intn_low", 64'(interruptn), 64'd0);
        do_cs(8, 64'h5C, 1'b0, 1'b1);
        chk("mid_resume_b0", 64'(got_byte(0)), 64'h22);
        chk("mid_rx_aligned", 64'(rx_got.size() > 0 ? rx_got[0] : 8'h00), 64'h5C);

        // csn rise together with the byte-ending fall: no load
        push_frame(8'h12, 1'b0);
        push_frame(8'h34, 1'b1);
        do_cs(4, 64'h0, 1'b1, 1'b1);
        chk("simul_b0", 64'(got_byte(0)), 64'h12);
        do_cs(4, 64'h0, 1'b0, 1'b1);
        chk("simul_next_b0", 64'(got_byte(0)), 64'h34);

        // tvalid gap mid-frame inserts the idle byte and keeps the frame open
        push_frame(8'h44, 1'b0);
        do_cs(8, 64'h0, 1'b0, 1'b1);
        chk("gap_b1", 64'(got_byte(1)), 64'hBC);
        chk("gap_intn", 64'(interruptn), 64'd0);
        push_frame(8'h55, 1'b1);
        do_cs(4, 64'h0, 1'b0, 1'b1);
        chk("gap_close_b0", 64'(got_byte(0)), 64'h55);

        // Randomized CS lengths, frames and MOSI data
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                int len;
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) push_frame(8'($urandom), b == len - 1);
            end
            do_cs($urandom_range(1, 20), {$urandom, $urandom}, $urandom_range(0, 3) == 0, 1'b1);
        end

        // Asynchronous reset in the middle of a byte
        push_frame(8'hFF, 1'b0);
        push_frame(8'hFF, 1'b1);
        tick(2);
        spi_csn = 1'b0;
        tick(H + 2);
        spi_clk = 1'b1;
        tick(H);
        spi_clk = 1'b0;
        tick(H);
        chk("prerst_miso", 64'(spi_miso), 64'd3);
        chk("prerst_intn", 64'(interruptn), 64'd0);
        #2 resn = 1'b0;
        #1;
        chk("rst_mid_miso", 64'(spi_miso), 64'd0);
        chk("rst_mid_intn", 64'(interruptn), 64'd1);
        chk("rst_mid_tready", 64'(s_axis_tready), 64'd0);
        tick(1);
        spi_csn = 1'b1;
        tx_q.delete();
        mdl_q.delete();
        mdl_in_frame = 1'b0;
        tick(3);
        resn = 1'b1;
        tick(6);
        chk("postrst_intn", 64'(interruptn), 64'd1);
        do_cs(4, 64'h0, 1'b0, 1'b1);
        chk("postrst_b0", 64'(got_byte(0)), 64'hBC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
